avr_fetch: RTL

AVR_FETCH -- requirements
Module: avr_fetch

---
 rtl/avr_pkg.sv | 24 ++
 rtl/avr_fetch_skid.sv | 33 +++
 rtl/avr_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/avr_pkg.sv
// Shared constants, FSM encoding and two-word opcode decode for the AVR fetch unit.
package avr_pkg;

  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

  // JMP/CALL: 1001_010x_xxxx_11xx    LDS/STS: 1001_00xx_xxxx_0000
  localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
  localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;
  localparam logic [15:0] LDS_STS_MASK   = 16'hFC0F;
  localparam logic [15:0] LDS_STS_MATCH  = 16'h9000;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WORD2 = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

  function automatic logic is_two_word(input logic [15:0] w);
    return ((w & JMP_CALL_MASK) == JMP_CALL_MATCH) ||
           ((w & LDS_STS_MASK)  == LDS_STS_MATCH);
  endfunction

endpackage

// File: rtl/avr_fetch_skid.sv
// One-entry hold buffer: captures the in-flight memory word on the first stalled
// edge and replays it on the release edge so nothing is lost while fetch_pc is held.
module avr_fetch_skid #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_stall,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_word;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_full <= 1'b0;
      r_word <= '0;
    end else if (i_stall) begin
      if (!r_full) begin
        r_full <= 1'b1;
        r_word <= i_data;
      end
    end else begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_full ? r_word : i_data;

endmodule

// File: rtl/avr_fetch.sv
// AVR instruction fetch: sequential program-memory addressing, two-word opcode
// assembly, branch redirect with two bubbles, and stall with skid replay.
//
// state | meaning
// FILL  | just out of reset; first word still in flight, incoming word discarded
// RUN   | streaming; each word is decoded and issued (or latched if two-word)
// WORD2 | first half of a two-word opcode held, waiting for its operand word
// FLUSH | after a redirect; discarding the second stale word
module avr_fetch
  import avr_pkg::*;
#(
  parameter int          PC_W     = 16,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [PC_W-1:0] p_addr,
  input  logic [15:0]     p_data,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  output logic [15:0]     instr,
  output logic [15:0]     instr_k,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_pc
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_data_pc;
  logic [15:0]     r_instr;
  logic [15:0]     r_instr_k;
  logic            r_instr_valid;
  logic [PC_W-1:0] r_instr_pc;
  logic [15:0]     r_first;
  logic [PC_W-1:0] r_first_pc;

  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] w_fetch_pc_nxt;
  logic [PC_W-1:0] w_data_pc_nxt;
  logic [15:0]     w_instr_nxt;
  logic [15:0]     w_instr_k_nxt;
  logic            w_instr_valid_nxt;
  logic [PC_W-1:0] w_instr_pc_nxt;
  logic [15:0]     w_first_nxt;
  logic [PC_W-1:0] w_first_pc_nxt;
  logic [15:0]     w_word;

  avr_fetch_skid #(.W(16)) u_skid (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (br_valid),
    .i_stall (stall),
    .i_data  (p_data),
    .o_data  (w_word)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_data_pc_nxt     = r_data_pc;
    w_instr_nxt       = r_instr;
    w_instr_k_nxt     = r_instr_k;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_pc_nxt    = r_instr_pc;
    w_first_nxt       = r_first;
    w_first_pc_nxt    = r_first_pc;

    if (br_valid) begin
      w_state_nxt       = ST_FLUSH;
      w_fetch_pc_nxt    = br_target;
      w_data_pc_nxt     = r_fetch_pc;
      w_instr_nxt       = NOP_WORD;
      w_instr_k_nxt     = 16'h0000;
      w_instr_valid_nxt = 1'b0;
    end else if (!stall) begin
      // r_data_pc always names the address whose word is consumed this edge
      w_fetch_pc_nxt    = r_fetch_pc + 1'b1;
      w_data_pc_nxt     = r_fetch_pc;
      w_instr_nxt       = NOP_WORD;
      w_instr_k_nxt     = 16'h0000;
      w_instr_valid_nxt = 1'b0;
      case (r_state)
        ST_FILL, ST_FLUSH: begin
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (is_two_word(w_word)) begin
            w_first_nxt    = w_word;
            w_first_pc_nxt = r_data_pc;
            w_state_nxt    = ST_WORD2;
          end else begin
            w_instr_nxt       = w_word;
            w_instr_valid_nxt = 1'b1;
            w_instr_pc_nxt    = r_data_pc;
          end
        end
        ST_WORD2: begin
          w_instr_nxt       = r_first;
          w_instr_k_nxt     = w_word;
          w_instr_valid_nxt = 1'b1;
          w_instr_pc_nxt    = r_first_pc;
          w_state_nxt       = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_FILL;
      r_fetch_pc    <= '0;
      r_data_pc     <= '0;
      r_instr       <= NOP_WORD;
      r_instr_k     <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= '0;
      r_first       <= NOP_WORD;
      r_first_pc    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_data_pc     <= w_data_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_k     <= w_instr_k_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_first       <= w_first_nxt;
      r_first_pc    <= w_first_pc_nxt;
    end
  end

  assign p_addr      = r_fetch_pc;
  assign instr       = r_instr;
  assign instr_k     = r_instr_k;
  assign instr_valid = r_instr_valid;
  assign instr_pc    = r_instr_pc;

endmodule
